// File: rtl/tcb_lib_arbiter_multiplexer.sv
// N-to-1 TCB arbiter and multiplexer: grants one of SPN request ports to a
// single manager-side port and routes each response back through a DLY-deep select pipe.
module tcb_lib_arbiter_multiplexer #(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned BEN = DAT/8,
  parameter int unsigned DLY = 1,
  parameter int unsigned SPN = 3,
  parameter int unsigned SPL = $clog2(SPN),
  parameter int unsigned MOD = 0,
  parameter int unsigned PRI [SPN-1:0] = '{2, 1, 0}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPN-1:0]     sub_vld,
  input  logic [SPN-1:0]     sub_wen,
  input  logic [SPN*ADR-1:0] sub_adr,
  input  logic [SPN*BEN-1:0] sub_ben,
  input  logic [SPN*DAT-1:0] sub_wdt,
  output logic [SPN-1:0]     sub_rdy,
  output logic [SPN*DAT-1:0] sub_rdt,
  output logic [SPN-1:0]     sub_err,
  output logic               man_vld,
  output logic               man_wen,
  output logic [ADR-1:0]     man_adr,
  output logic [BEN-1:0]     man_ben,
  output logic [DAT-1:0]     man_wdt,
  input  logic               man_rdy,
  input  logic [DAT-1:0]     man_rdt,
  input  logic               man_err,
  output logic [SPL-1:0]     sel
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t         state, state_nxt;
  logic [SPL-1:0] arb_sel, hold_sel, rr_ptr;
  logic           xfer;
  logic           rsp_act;
  logic [SPL-1:0] rsp_idx;

  assign man_vld = |sub_vld;
  assign xfer    = man_vld & man_rdy;

  // Idle (no valid port) resolves to index 0 in both modes.
  always_comb begin
    int unsigned best_pri;
    int unsigned nxt;
    logic        found;
    arb_sel  = '0;
    best_pri = 0;
    nxt      = 0;
    found    = 1'b0;
    if (MOD == 0) begin
      for (int unsigned i = 0; i < SPN; i++) begin
        if (sub_vld[i] && (!found || PRI[i] < best_pri)) begin
          found    = 1'b1;
          best_pri = PRI[i];
          arb_sel  = SPL'(i);
        end
      end
    end else begin
      for (int unsigned j = 1; j <= SPN; j++) begin
        nxt = (32'(rr_ptr) + j) % SPN;
        if (!found && sub_vld[nxt]) begin
          found   = 1'b1;
          arb_sel = SPL'(nxt);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB;
      hold_sel <= '0;
      rr_ptr   <= SPL'(SPN-1);
    end else begin
      state <= state_nxt;
      if (man_vld && !man_rdy) hold_sel <= sel;
      if (xfer)                rr_ptr   <= sel;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (man_vld && !man_rdy) state_nxt = HOLD;
      HOLD:    if (xfer)                state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    sel = (state == HOLD) ? hold_sel : arb_sel;
  end

  always_comb begin
    man_wen = 1'b0;
    man_adr = '0;
    man_ben = '0;
    man_wdt = '0;
    sub_rdy = '0;
    for (int unsigned i = 0; i < SPN; i++) begin
      if (man_vld && sel == SPL'(i)) begin
        man_wen    = sub_wen[i];
        man_adr    = sub_adr[i*ADR +: ADR];
        man_ben    = sub_ben[i*BEN +: BEN];
        man_wdt    = sub_wdt[i*DAT +: DAT];
        sub_rdy[i] = man_rdy;
      end
    end
  end

  if (DLY == 0) begin : g_nodly
    assign rsp_act = xfer;
    assign rsp_idx = sel;
  end else begin : g_dly
    logic [DLY-1:0] act_q;
    logic [SPL-1:0] idx_q [DLY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        act_q <= '0;
        for (int unsigned s = 0; s < DLY; s++) idx_q[s] <= '0;
      end else begin
        act_q[0] <= xfer;
        idx_q[0] <= sel;
        for (int unsigned s = 1; s < DLY; s++) begin
          act_q[s] <= act_q[s-1];
          idx_q[s] <= idx_q[s-1];
        end
      end
    end

    assign rsp_act = act_q[DLY-1];
    assign rsp_idx = idx_q[DLY-1];
  end

  always_comb begin
    sub_rdt = '0;
    sub_err = '0;
    for (int unsigned i = 0; i < SPN; i++) begin
      if (rsp_act && rsp_idx == SPL'(i)) begin
        sub_rdt[i*DAT +: DAT] = man_rdt;
        sub_err[i]            = man_err;
      end
    end
  end

endmodule

// File: doc/tcb_lib_arbiter_multiplexer.md
Name: tcb_lib_arbiter_multiplexer

Overview:
Parametrised N-to-1 TCB interconnect stage that merges arbitration and multiplexing into one block.
- Arbitrates between SPN subordinate-side ports (driven by managers) using fixed-priority or round-robin mode.
- Holds the grant while a request is stalled, and forwards the winner to a single manager-side port.
- Routes each read/error response back to its originating port through a DLY-deep select pipeline.
- Sits between CPU/DMA managers and a shared memory or peripheral subordinate.

Parameters:
- ADR, 32, address bus width
- DAT, 32, data bus width
- BEN, DAT/8, byte enable width
- DLY, 1, subordinate response delay in cycles (0..4)
- SPN, 3, number of subordinate-side ports (2..16)
- SPL, $clog2(SPN), select index width
- MOD, 0, arbitration mode: 0 = fixed priority, 1 = round-robin
- PRI, '{2,1,0}, per-port priority for MOD=0 (lower value wins; values unique)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- sub_vld  in  SPN  request valid per port
- sub_wen  in  SPN  write enable per port
- sub_adr  in  SPN×ADR  address per port
- sub_ben  in  SPN×BEN  byte enables per port
- sub_wdt  in  SPN×DAT  write data per port
- sub_rdy  out  SPN  ready per port
- sub_rdt  out  SPN×DAT  read data per port
- sub_err  out  SPN  error response per port
- man_vld  out  1  muxed request valid
- man_wen  out  1  muxed write enable
- man_adr  out  ADR  muxed address
- man_ben  out  BEN  muxed byte enables
- man_wdt  out  DAT  muxed write data
- man_rdy  in  1  subordinate ready
- man_rdt  in  DAT  subordinate read data, valid DLY cycles after transfer
- man_err  in  1  subordinate error, valid DLY cycles after transfer
- sel  out  SPL  current grant index (debug/observability)

Behaviour:
- Transfer: a transfer occurs on a clk edge where man_vld & man_rdy.
- Request path (combinational):
  - man_vld = |sub_vld.
  - man_* fields = fields of port sel.
  - sub_rdy[i] = man_rdy & man_vld & (sel==i).
  - When no port is valid, man_* fields are 0.
- Grant in MOD=0: the valid port with the lowest PRI value.
- Grant in MOD=1:
  - The first valid port scanning upward, modulo SPN, from rr_ptr+1.
  - rr_ptr updates to sel on each transfer only.
- Grant hold:
  - If man_vld & !man_rdy at an edge, set hold=1 and hold_sel=sel.
  - While hold=1, sel=hold_sel regardless of other requests.
  - hold clears on the transfer edge.
  - A stalled request must never be pre-empted by a higher-priority arrival.
- Response pipeline:
  - DLY-stage shift register of {act, idx}.
  - Stage 0 loads {1, sel} on transfer, else {0, x}.
  - Advances every cycle; back-to-back transfers are supported.
  - Output stage with act=1: sub_rdt[idx]=man_rdt and sub_err[idx]=man_err; all other ports get rdt=0, err=0.
  - DLY=0: routing uses the current sel combinationally.
- Reset (rst=0, asynchronous):
  - hold=0, rr_ptr=SPN-1 (port 0 first after reset), all pipeline act=0.
  - Hence sel=0, sub_rdt=0, sub_err=0.
  - man_vld/sub_rdy follow inputs combinationally; reset mid-operation discards in-flight responses.
- Boundaries:
  - rr_ptr wraps SPN-1→0.
  - A single requester is granted every cycle with no bubble.
  - Simultaneous stall release and new request: the new grant is computed the following cycle from the updated rr_ptr.
  - Ports with sub_vld=0 never receive sub_rdy.

Test Plan:
1. SPN=3, MOD=0, DLY=1: all ports write simultaneously (0x0/0x03020100, 0x4/0x13121110, 0xC/0x23222120), man_rdy=1 → transfers in order 0,1,2 on 3 consecutive cycles; sub_err all 0.
2. MOD=1: all 3 ports hold vld continuously for 6 transfers → grant order 0,1,2,0,1,2; rr_ptr wraps correctly.
3. Port 2 requests with man_rdy=0 for 3 cycles, then port 0 also requests (MOD=0) → sel stays 2 until man_rdy=1; port 0 is granted the next cycle.
4. Back-to-back reads from ports 1, 0, 2 with DLY=2; man_rdt returns 0x13121110, 0x03020100, 0x23222120 → each value appears only on the matching sub_rdt, 2 cycles after its transfer; other ports read 0.
5. man_err=1 on the second response of scenario 4 → only sub_err[0]=1, for one cycle.
6. rst driven low for 1 cycle while 2 reads are in flight → pipeline cleared, no sub_rdt/sub_err pulses; after release the first MOD=1 grant goes to port 0.
